// File: rtl/trace_pkg.sv
// Shared types and layout constants for the instruction trace buffer.
package trace_pkg;

    // Default field widths; the top recomputes its own widths from its parameters.
    localparam int unsigned ADDR_W_DEF = 13;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned OP_W_DEF   = 3;

    // Entry layout, LSB first: data, opcode, ir_addr, pc.
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned OP_LSB   = DATA_LSB + DATA_W_DEF;
    localparam int unsigned IR_LSB   = OP_LSB + OP_W_DEF;
    localparam int unsigned PC_LSB   = IR_LSB + ADDR_W_DEF;
    localparam int unsigned ENTRY_W  = 2 * ADDR_W_DEF + OP_W_DEF + DATA_W_DEF;

    // Capture state machine encoding (visible on the state output).
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StArmed  = 2'd1,
        StPost   = 2'd2,
        StFrozen = 2'd3
    } state_e;

    function automatic int unsigned entry_width(int unsigned aw, int unsigned ow,
                                                int unsigned dw);
        return 2 * aw + ow + dw;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: register array, one synchronous write port, one asynchronous read port.
module trace_ram
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = ENTRY_W,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Array cleared on reset so the show-ahead read fields read 0 when empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Instruction trace capture: delayed data sampling, circular buffer, halt-triggered freeze.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CAP_DLY = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [$clog2(DEPTH):0]   post_trig,
    input  logic                     clear,
    input  logic                     fetch,
    input  logic                     halt,
    input  logic [ADDR_W-1:0]        pc_addr,
    input  logic [ADDR_W-1:0]        ir_addr,
    input  logic [OP_W-1:0]          opcode,
    input  logic [DATA_W-1:0]        data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ADDR_W-1:0]        rd_pc,
    output logic [ADDR_W-1:0]        rd_ir_addr,
    output logic [OP_W-1:0]          rd_op,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               state
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = entry_width(ADDR_W, OP_W, DATA_W);
    localparam logic [PW:0] CNT_ONE = {{PW{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic                fetch_q, halt_q;
    logic                pend_q, pend_d;
    logic [3:0]          dly_q, dly_d;
    logic [ADDR_W-1:0]   pend_pc_q, pend_pc_d, pend_ir_q, pend_ir_d;
    logic [OP_W-1:0]     pend_op_q, pend_op_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]         count_q, count_d, post_q, post_d;
    logic                ovf_q, ovf_d;

    logic fetch_rise, halt_rise, capturing, commit, full, pop, accept;
    logic [EW-1:0] wdata, rdata;

    assign fetch_rise = fetch & ~fetch_q;
    assign halt_rise  = halt & ~halt_q;
    assign capturing  = enable && (state_q == StArmed || state_q == StPost);
    // A pending entry commits on delay expiry, or early when the next fetch arrives.
    assign commit     = capturing && pend_q && (dly_q == '0 || fetch_rise) && !clear;
    // DEPTH is a power of two and count never exceeds it, so the MSB alone means full.
    assign full       = count_q[PW];
    assign pop        = rd_valid && rd_ready && !clear;
    // When full, a write is taken only if it overwrites (wrap) or a pop frees the slot.
    assign accept     = commit && (!full || pop || !mode);

    assign wdata = {pend_pc_q, pend_ir_q, pend_op_q, data};
    assign {rd_pc, rd_ir_addr, rd_op, rd_data} = rdata;

    assign rd_valid = (count_q != '0);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign state    = state_q;

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Capture FSM next state and post-trigger countdown.
    always_comb begin
        state_d = state_q;
        post_d  = post_q;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StArmed;
                StArmed: begin
                    if (halt_rise) begin
                        if (post_trig == '0) begin
                            state_d = StFrozen;
                        end else begin
                            state_d = StPost;
                            post_d  = post_trig;
                        end
                    end
                end
                StPost: begin
                    if (commit) begin
                        post_d = post_q - 1'b1;
                        if (post_q == CNT_ONE) state_d = StFrozen;
                    end
                end
                StFrozen: state_d = StFrozen;
            endcase
        end
        if (clear) begin
            state_d = enable ? StArmed : StIdle;
            post_d  = '0;
        end
    end

    // Pending slot: latch fetch fields, count down to the data sample point.
    always_comb begin
        pend_d    = pend_q;
        dly_d     = dly_q;
        pend_pc_d = pend_pc_q;
        pend_ir_d = pend_ir_q;
        pend_op_d = pend_op_q;
        if (pend_q && dly_q != '0) dly_d = dly_q - 1'b1;
        if (commit) pend_d = 1'b0;
        if (capturing && fetch_rise) begin
            pend_d    = 1'b1;
            dly_d     = 4'(CAP_DLY);
            pend_pc_d = pc_addr;
            pend_ir_d = ir_addr;
            pend_op_d = opcode;
        end
        // Leaving the capture states (freeze, idle, flush) drops whatever is pending.
        if (clear || !(state_d == StArmed || state_d == StPost)) begin
            pend_d = 1'b0;
            dly_d  = '0;
        end
    end

    // Pointer, occupancy and overflow bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop || (accept && full)) rd_ptr_d = rd_ptr_q + 1'b1;
        if (accept && !pop && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !accept) begin
            count_d = count_q - 1'b1;
        end
        if (commit && full && !pop) ovf_d = 1'b1;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            fetch_q   <= 1'b0;
            halt_q    <= 1'b0;
            pend_q    <= 1'b0;
            dly_q     <= '0;
            pend_pc_q <= '0;
            pend_ir_q <= '0;
            pend_op_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            post_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            fetch_q   <= fetch;
            halt_q    <= halt;
            pend_q    <= pend_d;
            dly_q     <= dly_d;
            pend_pc_q <= pend_pc_d;
            pend_ir_q <= pend_ir_d;
            pend_op_q <= pend_op_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            post_q    <= post_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule
